// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: samples start/data/parity/stop on bit_en strobes and
// assembles a WIDTH-bit word delivered over a valid/ready handshake.
module serial_frame_receiver #(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             parity_err,
    output logic             framing_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             par_q, par_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             par_bad;

    assign par_bad = (PARITY_EN != 0) && (par_q != ^shift_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        par_d   = par_q;
        valid_d = valid_q;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (serial_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = {shift_q[WIDTH-2:0], serial_in};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_d   = serial_in;
                    state_d = STOP;
                end
                STOP: begin
                    // A high stop bit is an error, never the next start bit
                    state_d = IDLE;
                    if (serial_in) begin
                        ferr_d = 1'b1;
                    end else if (par_bad) begin
                        perr_d = 1'b1;
                    end else if (valid_q && !data_ready) begin
                        ovr_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign parity_err  = perr_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q != IDLE);

endmodule
